// File: rtl/pe_weight_loader.sv
`default_nettype none
//============================================================================
// Module : pe_weight_loader
// Brief  : Streams one tile of ROWS weight words into the top PE of a
//          systolic column, then issues a single weight-bank switch pulse.
//          Define WLOAD_REVERSE_EN to buffer the tile and emit it last-first.
// Rev    : 1.0 - initial release
//============================================================================
module pe_weight_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_weight_data,
    input  logic                  s_weight_valid,
    output logic                  s_weight_ready,
    input  logic                  sw_allow,
    output logic [DATA_WIDTH-1:0] pe_weight_out,
    output logic                  pe_accept_w_out,
    output logic                  pe_switch_out,
    output logic                  busy,
    output logic                  tile_done
);

    localparam int c_cnt_w = $clog2(ROWS) + 1;
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_last_m1 = c_cnt_w'(ROWS - 1);

`ifdef WLOAD_REVERSE_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SW_WAIT = 3'd2,
        SWITCH  = 3'd3,
        EMIT    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SW_WAIT = 3'd2,
        SWITCH  = 3'd3
    } state_t;
`endif

    state_t                r_state;
    logic [c_cnt_w-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_weight;
    logic                  r_accept;
    logic                  r_switch;
    logic                  r_done;
    logic                  r_ready;
    logic                  w_hs;

    assign w_hs = s_weight_valid && r_ready;

`ifdef WLOAD_REVERSE_EN
    localparam logic [c_cnt_w-2:0] c_idx_one = (c_cnt_w-1)'(1);

    logic [DATA_WIDTH-1:0] r_buf [ROWS];
    logic [c_cnt_w-2:0]    w_cap_idx;
    logic [c_cnt_w-2:0]    w_emit_idx;

    // Count is the next capture slot while loading and one past the next
    // word to emit while draining, so both indices fall out of it directly.
    assign w_cap_idx  = r_count[c_cnt_w-2:0];
    assign w_emit_idx = r_count[c_cnt_w-2:0] - c_idx_one;

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_buf[w_cap_idx] <= s_weight_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_weight <= '0;
            r_accept <= 1'b0;
            r_switch <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_accept <= 1'b0;
            r_switch <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_hs) begin
                        r_count <= c_one;
                        r_state <= LOAD;
`ifndef WLOAD_REVERSE_EN
                        r_weight <= s_weight_data;
                        r_accept <= 1'b1;
`endif
                    end
                end
                LOAD: begin
                    if (w_hs) begin
                        r_count <= r_count + c_one;
`ifndef WLOAD_REVERSE_EN
                        r_weight <= s_weight_data;
                        r_accept <= 1'b1;
`endif
                        if (r_count == c_last_m1) begin
                            r_ready <= 1'b0;
`ifdef WLOAD_REVERSE_EN
                            r_state <= EMIT;
`else
                            r_state <= SW_WAIT;
`endif
                        end
                    end
                end
`ifdef WLOAD_REVERSE_EN
                EMIT: begin
                    r_weight <= r_buf[w_emit_idx];
                    r_accept <= 1'b1;
                    r_count  <= r_count - c_one;
                    if (r_count == c_one) begin
                        r_state <= SW_WAIT;
                    end
                end
`endif
                SW_WAIT: begin
                    // Hold off one cycle after the last shift so the switch
                    // never lands right behind an accept pulse.
                    if (sw_allow && !r_accept) begin
                        r_state  <= SWITCH;
                        r_switch <= 1'b1;
                        r_done   <= 1'b1;
                    end
                end
                SWITCH: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign s_weight_ready  = r_ready;
    assign pe_weight_out   = r_weight;
    assign pe_accept_w_out = r_accept;
    assign pe_switch_out   = r_switch;
    assign tile_done       = r_done;
    assign busy            = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pe_weight_loader.sv
`default_nettype none
//============================================================================
// Module : tb_pe_weight_loader
// Brief  : Directed self-checking bench for pe_weight_loader (ROWS=4).
// Rev    : 1.0 - initial release
//============================================================================
module tb_pe_weight_loader;

    localparam int DW   = 16;
    localparam int ROWS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_weight_data = '0;
    logic          s_weight_valid = 1'b0;
    logic          s_weight_ready;
    logic          sw_allow = 1'b0;
    logic [DW-1:0] pe_weight_out;
    logic          pe_accept_w_out;
    logic          pe_switch_out;
    logic          busy;
    logic          tile_done;

    pe_weight_loader #(.DATA_WIDTH(DW), .ROWS(ROWS)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_weight_data  (s_weight_data),
        .s_weight_valid (s_weight_valid),
        .s_weight_ready (s_weight_ready),
        .sw_allow       (sw_allow),
        .pe_weight_out  (pe_weight_out),
        .pe_accept_w_out(pe_accept_w_out),
        .pe_switch_out  (pe_switch_out),
        .busy           (busy),
        .tile_done      (tile_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int overlap = 0;

    logic [DW-1:0] acc_data [$];
    int acc_cyc  [$];
    int sw_cyc   [$];
    int done_cyc [$];
    int hs_cyc   [$];

    logic [DW-1:0] tile_a [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    logic [DW-1:0] tile_b [4] = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04};

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are logged with the index of the cycle they complete in;
    // outputs are logged mid-cycle, one index later for a registered result.
    always @(posedge clk) begin
        if (!rst && s_weight_valid && s_weight_ready) hs_cyc.push_back(cyc);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (pe_accept_w_out) begin
                acc_data.push_back(pe_weight_out);
                acc_cyc.push_back(cyc);
            end
            if (pe_switch_out) sw_cyc.push_back(cyc);
            if (tile_done) done_cyc.push_back(cyc);
            if (pe_accept_w_out && pe_switch_out) overlap++;
        end
    end

    function automatic int ord(input int i);
`ifdef WLOAD_REVERSE_EN
        return 3 - i;
`else
        return i;
`endif
    endfunction

    task automatic clear_logs();
        acc_data.delete(); acc_cyc.delete(); sw_cyc.delete();
        done_cyc.delete(); hs_cyc.delete();
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        int n;
        s_weight_data  = d;
        s_weight_valid = 1'b1;
        n = 0;
        while (!s_weight_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: ready low for %0d cycles, required high within 50", n);
        end
        @(negedge clk);
        s_weight_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (pe_weight_out !== 16'h0) begin errors++; $display("FAIL rst_weight: got %h expected 0000", pe_weight_out); end
        checks++; if (pe_accept_w_out !== 1'b0) begin errors++; $display("FAIL rst_accept: got %b expected 0", pe_accept_w_out); end
        checks++; if (pe_switch_out !== 1'b0) begin errors++; $display("FAIL rst_switch: got %b expected 0", pe_switch_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", tile_done); end
        checks++; if (s_weight_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", s_weight_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (s_weight_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", s_weight_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        sw_allow = 1'b1;
        clear_logs();
        for (int i = 0; i < 4; i++) send_word(tile_a[i]);
        repeat (12) @(negedge clk);
        checks++;
        if (acc_data.size() != 4 || sw_cyc.size() != 1 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL basic_counts: accepts %0d switches %0d dones %0d, expected 4 1 1",
                     acc_data.size(), sw_cyc.size(), done_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_data[i] !== tile_a[ord(i)]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, acc_data[i], tile_a[ord(i)]); end
                checks++;
                if (acc_cyc[i] != acc_cyc[0] + i) begin errors++; $display("FAIL basic_accept_cyc[%0d]: got %0d expected %0d", i, acc_cyc[i], acc_cyc[0] + i); end
            end
`ifndef WLOAD_REVERSE_EN
            checks++;
            if (acc_cyc[0] != hs_cyc[0] + 1) begin errors++; $display("FAIL basic_latency: accept at %0d expected %0d", acc_cyc[0], hs_cyc[0] + 1); end
`endif
            checks++;
            if (sw_cyc[0] != acc_cyc[3] + 2) begin errors++; $display("FAIL basic_switch_cyc: got %0d expected %0d", sw_cyc[0], acc_cyc[3] + 2); end
            checks++;
            if (done_cyc[0] != sw_cyc[0]) begin errors++; $display("FAIL basic_done_cyc: got %0d expected %0d", done_cyc[0], sw_cyc[0]); end
        end
    endtask

    task automatic test_stall();
        sw_allow = 1'b1;
        clear_logs();
        send_word(tile_a[0]);
        send_word(tile_a[1]);
        repeat (2) begin
            @(negedge clk);
`ifndef WLOAD_REVERSE_EN
            checks++;
            if (pe_accept_w_out !== 1'b0 || pe_weight_out !== 16'h0200) begin
                errors++;
                $display("FAIL stall_bubble: accept %b weight %h, expected 0 0200", pe_accept_w_out, pe_weight_out);
            end
`endif
        end
        send_word(tile_a[2]);
        send_word(tile_a[3]);
        repeat (12) @(negedge clk);
        checks++;
        if (acc_data.size() != 4 || sw_cyc.size() != 1) begin
            errors++;
            $display("FAIL stall_counts: accepts %0d switches %0d, expected 4 1", acc_data.size(), sw_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_data[i] !== tile_a[ord(i)]) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", i, acc_data[i], tile_a[ord(i)]); end
            end
`ifndef WLOAD_REVERSE_EN
            checks++;
            if (acc_cyc[2] != acc_cyc[1] + 3) begin errors++; $display("FAIL stall_gap: third accept %0d expected %0d", acc_cyc[2], acc_cyc[1] + 3); end
            checks++;
            if (sw_cyc[0] != acc_cyc[0] + 7) begin errors++; $display("FAIL stall_switch_cyc: got %0d expected %0d", sw_cyc[0], acc_cyc[0] + 7); end
`else
            checks++;
            if (sw_cyc[0] != acc_cyc[3] + 2) begin errors++; $display("FAIL stall_switch_cyc: got %0d expected %0d", sw_cyc[0], acc_cyc[3] + 2); end
`endif
        end
    endtask

    task automatic test_sw_wait();
        int rise;
        sw_allow = 1'b0;
        clear_logs();
        for (int i = 0; i < 4; i++) send_word(tile_a[i]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || s_weight_ready !== 1'b0 || pe_switch_out !== 1'b0) begin
                errors++;
                $display("FAIL swwait_hold[%0d]: busy %b ready %b switch %b, expected 1 0 0", k, busy, s_weight_ready, pe_switch_out);
            end
        end
        sw_allow = 1'b1;
        rise = cyc;
        repeat (6) @(negedge clk);
        checks++;
        if (sw_cyc.size() != 1) begin
            errors++;
            $display("FAIL swwait_count: got %0d switch pulses expected 1", sw_cyc.size());
        end else if (sw_cyc[0] != rise + 1) begin
            errors++;
            $display("FAIL swwait_cyc: switch at %0d expected %0d", sw_cyc[0], rise + 1);
        end
    endtask

    task automatic test_reset_mid();
        sw_allow = 1'b1;
        clear_logs();
        send_word(tile_a[0]);
        send_word(tile_a[1]);
        rst = 1'b1;
        #1;
        checks++;
        if ({pe_weight_out, pe_accept_w_out, pe_switch_out, busy, tile_done, s_weight_ready} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: weight %h accept %b switch %b busy %b done %b ready %b, expected all 0",
                     pe_weight_out, pe_accept_w_out, pe_switch_out, busy, tile_done, s_weight_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sw_cyc.size() != 0) begin errors++; $display("FAIL midrst_no_switch: got %0d pulses expected 0", sw_cyc.size()); end
        clear_logs();
        for (int i = 0; i < 4; i++) send_word(tile_b[i]);
        repeat (12) @(negedge clk);
        checks++;
        if (acc_data.size() != 4 || sw_cyc.size() != 1) begin
            errors++;
            $display("FAIL midrst_counts: accepts %0d switches %0d, expected 4 1", acc_data.size(), sw_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_data[i] !== tile_b[ord(i)]) begin errors++; $display("FAIL midrst_data[%0d]: got %h expected %h", i, acc_data[i], tile_b[ord(i)]); end
            end
            checks++;
            if (sw_cyc[0] != acc_cyc[3] + 2) begin errors++; $display("FAIL midrst_switch_cyc: got %0d expected %0d", sw_cyc[0], acc_cyc[3] + 2); end
        end
    endtask

    task automatic test_back_to_back();
        sw_allow = 1'b1;
        clear_logs();
        overlap = 0;
        for (int i = 0; i < 4; i++) send_word(tile_a[i]);
        for (int i = 0; i < 4; i++) send_word(tile_b[i]);
        repeat (15) @(negedge clk);
        checks++;
        if (done_cyc.size() != 2 || sw_cyc.size() != 2 || hs_cyc.size() != 8 || acc_data.size() != 8) begin
            errors++;
            $display("FAIL b2b_counts: dones %0d switches %0d handshakes %0d accepts %0d, expected 2 2 8 8",
                     done_cyc.size(), sw_cyc.size(), hs_cyc.size(), acc_data.size());
        end else begin
            checks++;
            if (hs_cyc[4] <= sw_cyc[0]) begin errors++; $display("FAIL b2b_early_accept: second tile handshake at %0d, switch at %0d", hs_cyc[4], sw_cyc[0]); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_data[i] !== tile_a[ord(i)] || acc_data[i+4] !== tile_b[ord(i)]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h/%h expected %h/%h", i, acc_data[i], acc_data[i+4], tile_a[ord(i)], tile_b[ord(i)]);
                end
            end
            for (int t = 0; t < 2; t++) begin
                checks++;
                if (done_cyc[t] != sw_cyc[t]) begin errors++; $display("FAIL b2b_done_cyc[%0d]: got %0d expected %0d", t, done_cyc[t], sw_cyc[t]); end
            end
        end
        checks++;
        if (overlap != 0) begin errors++; $display("FAIL accept_switch_overlap: got %0d cycles expected 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_sw_wait();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pe_weight_loader.md
PE_WEIGHT_LOADER -- requirements
Module: pe_weight_loader

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the weight word width in bits (signed fixed-point, passed through unmodified).
REQ-002 The module SHALL have parameter ROWS, default 4 (legal range 2..64), giving the PE column depth, which is also the number of weight words per tile.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port s_weight_data, input, DATA_WIDTH bits: upstream weight word, signed.
REQ-006 The module SHALL have port s_weight_valid, input, 1 bit: s_weight_data is valid this cycle.
REQ-007 The module SHALL have port s_weight_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-008 The module SHALL have port sw_allow, input, 1 bit: the array permits a weight-bank switch this cycle.
REQ-009 The module SHALL have port pe_weight_out, output, DATA_WIDTH bits: drives pe_weight_in of the top PE of the column.
REQ-010 The module SHALL have port pe_accept_w_out, output, 1 bit: drives pe_accept_w_in of the top PE; each high cycle shifts the column by one word.
REQ-011 The module SHALL have port pe_switch_out, output, 1 bit: drives pe_switch_in of the top PE as a single-cycle pulse.
REQ-012 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The module SHALL have port tile_done, output, 1 bit: a one-cycle pulse coincident with pe_switch_out.

Function
REQ-014 The module SHALL implement the states IDLE, LOAD, SW_WAIT and SWITCH (plus EMIT when WLOAD_REVERSE_EN is defined), held in a word counter of width clog2(ROWS)+1.
REQ-015 A handshake SHALL occur only on a cycle where s_weight_valid && s_weight_ready are both high; s_weight_ready SHALL be high only in IDLE and LOAD.
REQ-016 In IDLE, a handshake SHALL load count=1 and go to LOAD; otherwise the module SHALL stay in IDLE.
REQ-017 In LOAD, each handshake SHALL increment count; the handshake that makes count equal ROWS SHALL move the module to SW_WAIT.
REQ-018 Upstream stalls (valid low) SHALL produce bubbles in which pe_accept_w_out=0 and pe_weight_out holds its value; a stall SHALL never abort the tile.
REQ-019 All PE-side outputs SHALL be registered: a word accepted at cycle t SHALL appear on pe_weight_out with pe_accept_w_out=1 at cycle t+1.
REQ-020 In SW_WAIT, the module SHALL stay while sw_allow=0 and SHALL go to SWITCH on the first cycle sw_allow=1.
REQ-021 In SWITCH, pe_switch_out=1 and tile_done=1 SHALL be asserted for exactly one cycle, after which the module SHALL return to IDLE.
REQ-022 The earliest switch pulse SHALL occur 2 cycles after the last accept pulse (accept at t+1, SW_WAIT, SWITCH at t+3 with sw_allow already high).
REQ-023 pe_accept_w_out and pe_switch_out SHALL never be high in the same cycle.
REQ-024 A new tile SHALL be accepted no earlier than the cycle after SWITCH.

Reset
REQ-025 While rst=1, state=IDLE, count=0, and pe_weight_out=0, pe_accept_w_out=0, pe_switch_out=0, busy=0, tile_done=0, s_weight_ready=0.
REQ-026 Reset asserted mid-tile SHALL discard the partial tile, produce no switch pulse, and start the next tile from word 0.
REQ-027 s_weight_ready SHALL go high in the first cycle after rst deasserts.

Configuration
REQ-028 The macro WLOAD_REVERSE_EN SHALL select the word ordering.
REQ-029 With WLOAD_REVERSE_EN undefined, words SHALL be forwarded in arrival order, so the first word lands in the bottom PE; no buffer SHALL be instantiated.
REQ-030 With WLOAD_REVERSE_EN defined, LOAD SHALL only capture words into a ROWS-entry buffer with pe_accept_w_out=0; EMIT SHALL then drive ROWS back-to-back accept cycles in order last-first before SW_WAIT, so the first word lands in the top PE.

Verification
REQ-031 ROWS=4, words 0x0100,0x0200,0x0300,0x0400 back-to-back, sw_allow=1 -> accept pulses on 4 consecutive cycles carrying the same order, then switch/tile_done two cycles after the last accept.
REQ-032 The same tile with valid low for 2 cycles after word 2 -> a 2-cycle accept bubble with pe_weight_out held at 0x0200, and the switch pulse delayed by 2 cycles.
REQ-033 sw_allow held 0 for 5 cycles after the last accept -> busy=1 and ready=0 throughout the wait, then one switch pulse the cycle after sw_allow rises.
REQ-034 rst asserted after word 2 of a tile -> all outputs 0 immediately, no switch pulse, and the next 4-word tile loads correctly.
REQ-035 WLOAD_REVERSE_EN defined, with the tile of REQ-031 -> emitted order 0x0400,0x0300,0x0200,0x0100 on 4 consecutive accept cycles, then the switch pulse.
REQ-036 Two tiles presented back-to-back -> the second tile's first handshake occurs no earlier than the cycle after the first tile's SWITCH, and tile_done pulses twice.
